// File: rtl/pixel_blend.sv
// Three-stage weighted blend of smooth/fine interpolated pixels with round-to-nearest
// division by 255, clamping, and delivered/clamped beat counters.
module pixel_blend #(
   parameter int pixelBitWidth = 12,
   parameter int cntBitWidth   = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [pixelBitWidth-1:0] pix_s,
   input  logic [pixelBitWidth-1:0] pix_f,
   input  logic [7:0]               w_s,
   input  logic [7:0]               w_f,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [pixelBitWidth-1:0] pix_out,
   output logic [cntBitWidth-1:0]   pix_cnt,
   output logic [15:0]              clamp_cnt
);

   localparam int PW    = pixelBitWidth;
   localparam int SUM_W = PW + 10;
   localparam int EXT_W = SUM_W + 1;

   localparam logic [PW-1:0]          PIX_MAX   = {PW{1'b1}};
   localparam logic [EXT_W-1:0]       ROUND_C   = {{(EXT_W-8){1'b0}}, 8'd128};
   localparam logic [EXT_W-1:0]       Q_MAX     = {{(EXT_W-PW){1'b0}}, PIX_MAX};
   localparam logic [cntBitWidth-1:0] CNT_ONE   = {{(cntBitWidth-1){1'b0}}, 1'b1};
   localparam logic [15:0]            CLAMP_MAX = 16'hFFFF;
   localparam logic [15:0]            CLAMP_ONE = 16'h0001;

   // Divide by 255 with rounding: t = sum+128, q = (t + t/256)/256; result {clamped, pixel}.
   function automatic logic [PW:0] norm_clamp(input logic [SUM_W-1:0] sum);
      logic [EXT_W-1:0] t;
      logic [EXT_W-1:0] q;
      t = {1'b0, sum} + ROUND_C;
      q = (t + (t >> 4'd8)) >> 4'd8;
      if (q > Q_MAX) begin
         return {1'b1, PIX_MAX};
      end else begin
         return {1'b0, q[PW-1:0]};
      end
   endfunction

   // Rounded mean (a+b+1)>>1 written without a carry bit that would later be dropped.
   function automatic logic [PW-1:0] round_avg(input logic [PW-1:0] a, input logic [PW-1:0] b);
      return (a >> 1'b1) + (b >> 1'b1) + {{(PW-1){1'b0}}, (a[0] | b[0])};
   endfunction

   logic             advance_s;
   logic             out_fire_s;

   logic             s1_valid_r;
   logic [PW-1:0]    s1_pix_s_r;
   logic [PW-1:0]    s1_pix_f_r;
   logic [7:0]       s1_w_s_r;
   logic [7:0]       s1_w_f_r;

   logic [SUM_W-1:0] s2_sum_s;
   logic [PW-1:0]    s2_avg_s;
   logic             s2_bypass_s;
   logic             s2_valid_r;
   logic [SUM_W-1:0] s2_sum_r;
   logic [PW-1:0]    s2_avg_r;
   logic             s2_bypass_r;

   logic [PW:0]      s3_norm_s;
   logic [PW-1:0]    s3_pix_s;
   logic             s3_clamp_s;
   logic             s3_valid_r;
   logic [PW-1:0]    s3_pix_r;
   logic             s3_clamp_r;

   logic [cntBitWidth-1:0] pix_cnt_r;
   logic [15:0]            clamp_cnt_r;

   // The whole pipeline moves as one: it shifts unless the output beat is stalled.
   assign advance_s  = out_ready | ~s3_valid_r;
   assign out_fire_s = s3_valid_r & out_ready;
   assign in_ready   = advance_s;

   assign out_valid  = s3_valid_r;
   assign pix_out    = s3_pix_r;
   assign pix_cnt    = pix_cnt_r;
   assign clamp_cnt  = clamp_cnt_r;

   // Stage 1: capture the input beat (or a bubble).
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_pix_s_r <= {PW{1'b0}};
         s1_pix_f_r <= {PW{1'b0}};
         s1_w_s_r   <= 8'd0;
         s1_w_f_r   <= 8'd0;
      end else if (advance_s) begin
         s1_valid_r <= in_valid;
         s1_pix_s_r <= pix_s;
         s1_pix_f_r <= pix_f;
         s1_w_s_r   <= w_s;
         s1_w_f_r   <= w_f;
      end else begin
         s1_valid_r <= s1_valid_r;
      end
   end

   // Stage 2 datapath: full-width weighted sum plus the zero-weight fallback.
   always_comb begin
      s2_sum_s    = ({{(SUM_W-PW){1'b0}}, s1_pix_s_r} * {{(SUM_W-8){1'b0}}, s1_w_s_r})
                  + ({{(SUM_W-PW){1'b0}}, s1_pix_f_r} * {{(SUM_W-8){1'b0}}, s1_w_f_r});
      s2_avg_s    = round_avg(s1_pix_s_r, s1_pix_f_r);
      s2_bypass_s = (s1_w_s_r == 8'd0) && (s1_w_f_r == 8'd0);
   end

   // Stage 2 register.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_r  <= 1'b0;
         s2_sum_r    <= {SUM_W{1'b0}};
         s2_avg_r    <= {PW{1'b0}};
         s2_bypass_r <= 1'b0;
      end else if (advance_s) begin
         s2_valid_r  <= s1_valid_r;
         s2_sum_r    <= s2_sum_s;
         s2_avg_r    <= s2_avg_s;
         s2_bypass_r <= s2_bypass_s;
      end else begin
         s2_valid_r  <= s2_valid_r;
      end
   end

   // Stage 3 datapath: normalise and clamp, or take the average when both weights were zero.
   always_comb begin
      s3_norm_s = norm_clamp(s2_sum_r);
      if (s2_bypass_r) begin
         s3_pix_s   = s2_avg_r;
         s3_clamp_s = 1'b0;
      end else begin
         s3_pix_s   = s3_norm_s[PW-1:0];
         s3_clamp_s = s3_norm_s[PW];
      end
   end

   // Stage 3 register drives the output; it holds while downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s3_valid_r <= 1'b0;
         s3_pix_r   <= {PW{1'b0}};
         s3_clamp_r <= 1'b0;
      end else if (advance_s) begin
         s3_valid_r <= s2_valid_r;
         s3_pix_r   <= s3_pix_s;
         s3_clamp_r <= s3_clamp_s;
      end else begin
         s3_valid_r <= s3_valid_r;
      end
   end

   // Delivered-beat counters; the clamp counter saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_cnt_r   <= {cntBitWidth{1'b0}};
         clamp_cnt_r <= 16'd0;
      end else if (out_fire_s) begin
         pix_cnt_r <= pix_cnt_r + CNT_ONE;
         if (s3_clamp_r && (clamp_cnt_r != CLAMP_MAX)) begin
            clamp_cnt_r <= clamp_cnt_r + CLAMP_ONE;
         end else begin
            clamp_cnt_r <= clamp_cnt_r;
         end
      end else begin
         pix_cnt_r   <= pix_cnt_r;
         clamp_cnt_r <= clamp_cnt_r;
      end
   end

endmodule

// File: tb/tb_pixel_blend.sv
// Directed bench for pixel_blend: hand-computed blends, clamp, bypass, stall and reset.
module tb_pixel_blend;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] pix_s = 12'd0;
   logic [11:0] pix_f = 12'd0;
   logic [7:0]  w_s = 8'd0;
   logic [7:0]  w_f = 8'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [11:0] pix_out;
   logic [23:0] pix_cnt;
   logic [15:0] clamp_cnt;

   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;
   int exp_clamp = 0;
   int oi = 0;
   int bi = 0;

   pixel_blend #(.pixelBitWidth(12), .cntBitWidth(24)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .pix_s(pix_s), .pix_f(pix_f), .w_s(w_s), .w_f(w_f),
      .out_valid(out_valid), .out_ready(out_ready), .pix_out(pix_out),
      .pix_cnt(pix_cnt), .clamp_cnt(clamp_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] beat_val(input int i);
      return 12'(500 + 111 * i);
   endfunction

   // One beat through an otherwise idle pipe: visible after exactly three edges.
   task automatic single(input string tag, input int ps, input int pf, input int ws, input int wf,
                         input int exp_pix, input int clamped);
      pix_s = 12'(ps); pix_f = 12'(pf); w_s = 8'(ws); w_f = 8'(wf);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check({tag, "_early"}, 32'(out_valid), 0);
      step();
      check({tag, "_valid"}, 32'(out_valid), 1);
      check({tag, "_pix"}, 32'(pix_out), exp_pix);
      step();
      exp_cnt++;
      exp_clamp += clamped;
      check({tag, "_pix_cnt"}, 32'(pix_cnt), exp_cnt);
      check({tag, "_clamp_cnt"}, 32'(clamp_cnt), exp_clamp);
      check({tag, "_drained"}, 32'(out_valid), 0);
   endtask

   initial begin
      // Reset with a beat presented; it must not be captured.
      pix_s = 12'd777; w_s = 8'd255; in_valid = 1'b1;
      step();
      step();
      rst = 1'b0; in_valid = 1'b0;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_pix_out", 32'(pix_out), 0);
      check("rst_pix_cnt", 32'(pix_cnt), 0);
      check("rst_clamp_cnt", 32'(clamp_cnt), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("rst_no_ghost", 32'(out_valid), 0);
      end

      single("full_smooth", 4095, 0, 255, 0, 4095, 0);
      single("mix", 1000, 2000, 128, 127, 1498, 0);
      single("clamp", 4095, 4095, 255, 255, 4095, 1);
      single("bypass", 100, 201, 0, 0, 151, 0);
      single("bypass_max", 4095, 4095, 0, 0, 4095, 0);
      single("tiny", 255, 0, 1, 1, 1, 0);

      // Clear counters before the stream so it can be counted from zero.
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_cnt = 0; exp_clamp = 0;
      check("srst_pix_cnt", 32'(pix_cnt), 0);
      check("srst_clamp_cnt", 32'(clamp_cnt), 0);

      // Eight beats, with the output stalled for four cycles once three are in flight.
      w_s = 8'd255; w_f = 8'd0; pix_f = 12'd0;
      oi = 0; bi = 0;
      for (int c = 0; c < 40 && oi < 8; c++) begin
         out_ready = !(c >= 3 && c <= 6);
         in_valid = (bi < 8);
         pix_s = (bi < 8) ? beat_val(bi) : 12'd0;
         #1;
         if (c >= 3 && c <= 6) begin
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_pix_hold", 32'(pix_out), 32'(beat_val(0)));
         end
         if (out_valid && out_ready) begin
            check("stream_order", 32'(pix_out), 32'(beat_val(oi)));
            oi++;
         end
         if (in_valid && in_ready) bi++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      exp_cnt = 8;
      check("stream_delivered", oi, 8);
      check("stream_pix_cnt", 32'(pix_cnt), exp_cnt);
      check("stream_idle", 32'(out_valid), 0);

      single("clamp2", 4095, 4095, 255, 255, 4095, 1);

      // Two beats in flight, then a one-cycle reset: neither may ever emerge.
      pix_s = 12'd1234; pix_f = 12'd0; w_s = 8'd255; w_f = 8'd0; in_valid = 1'b1;
      step();
      pix_s = 12'd2345;
      step();
      in_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 0);
      check("midrst_pix_cnt", 32'(pix_cnt), 0);
      check("midrst_clamp_cnt", 32'(clamp_cnt), 0);
      check("midrst_in_ready", 32'(in_ready), 1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("midrst_no_ghost", 32'(out_valid), 0);
      end
      check("midrst_cnt_stays", 32'(pix_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pixel_blend.md
PIXEL_BLEND -- requirements
Module: pixel_blend

Interface
REQ-001 The block SHALL have parameter pixelBitWidth, default 12, giving the pixel sample width.
REQ-002 The block SHALL have parameter cntBitWidth, default 24, giving the output-pixel counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an input beat is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 The block SHALL have port pix_s, input, pixelBitWidth bits: the smooth-direction interpolated pixel.
REQ-008 The block SHALL have port pix_f, input, pixelBitWidth bits: the fine-direction interpolated pixel.
REQ-009 The block SHALL have port w_s, input, 8 bits: the smooth weight, 0..255, taken from the weight stage.
REQ-010 The block SHALL have port w_f, input, 8 bits: the fine weight, 0..255, taken from the weight stage.
REQ-011 The block SHALL have port out_valid, output, 1 bit: pix_out holds a valid result.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts pix_out.
REQ-013 The block SHALL have port pix_out, output, pixelBitWidth bits: the blended pixel.
REQ-014 The block SHALL have port pix_cnt, output, cntBitWidth bits: the count of delivered output beats.
REQ-015 The block SHALL have port clamp_cnt, output, 16 bits: the count of delivered beats that were clamped.

Function
REQ-016 The block SHALL implement a transfer as valid&&ready on the same clock edge, on both input and output.
REQ-017 The block SHALL use three register stages: S1 registers the inputs, S2 forms the products and the sum, S3 normalizes and clamps and drives pix_out.
REQ-018 The block SHALL compute advance = out_ready || !out_valid; when advance=1 all stages shift, and when advance=0 all stages hold.
REQ-019 The block SHALL drive in_ready = advance combinationally; a stall SHALL NOT drop, duplicate or reorder any beat.
REQ-020 The block SHALL carry a valid bit per stage; a stage loaded with no input beat carries a bubble, and bubbles shift like data.
REQ-021 The block SHALL have a latency of exactly 3 cycles from input transfer to out_valid when out_ready is held at 1, with throughput of 1 beat per cycle.
REQ-022 S2 SHALL compute sum = pix_s*w_s + pix_f*w_f as an unsigned value of at least 22 bits with no truncation; the maximum is 2088450.
REQ-023 S3 SHALL compute t = sum+128, then q = (t + (t>>8)) >> 8, using at least 22 bits.
REQ-024 S3 SHALL set pix_out = q when q <= 2^pixelBitWidth-1, and otherwise SHALL set pix_out = 2^pixelBitWidth-1 and mark the beat as clamped.
REQ-025 When w_s=0 and w_f=0, the block SHALL bypass the weighted sum and set pix_out = (pix_s+pix_f+1)>>1; such a beat is never clamped.
REQ-026 pix_cnt SHALL increment by 1 on each output transfer, wrapping modulo 2^cntBitWidth.
REQ-027 clamp_cnt SHALL increment on each output transfer of a clamped beat and SHALL saturate at 65535.
REQ-028 pix_out SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-029 While rst=1, the block SHALL clear all stage valid bits, out_valid, pix_out, pix_cnt and clamp_cnt to 0 on the clock edge; in_ready SHALL follow REQ-018 and therefore read 1.
REQ-030 A reset asserted mid-stream SHALL discard all in-flight beats, and no beat accepted before reset SHALL appear at the output afterwards.
REQ-031 An input presented during the reset cycle SHALL NOT be captured.

Verification
REQ-032 The bench SHALL apply pix_s=4095, w_s=255, pix_f=0, w_f=0 -> pix_out=4095 three cycles later, with clamp_cnt unchanged.
REQ-033 The bench SHALL apply pix_s=1000, pix_f=2000, w_s=128, w_f=127 -> sum=382000, pix_out=1498.
REQ-034 The bench SHALL apply w_s=w_f=255 with pix_s=pix_f=4095 -> q=8190, pix_out=4095, clamp_cnt incremented by 1.
REQ-035 The bench SHALL apply w_s=w_f=0 with pix_s=100, pix_f=201 -> pix_out=151.
REQ-036 The bench SHALL stream 8 beats, hold out_ready=0 for 4 cycles with 3 beats in flight -> in_ready=0, pix_out stable, all 8 beats delivered in order, pix_cnt=8.
REQ-037 The bench SHALL assert rst for 1 cycle with 2 beats in flight -> on the next cycle out_valid=0 and the counters read 0, and neither of those beats is ever output.
